// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding,
// BCD digit type and per-digit roll-over limits.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_PAUSE = 2'd3
   } state_e;

   typedef logic [3:0] bcd_t;

   // Units digits roll over after 9, tens-of-seconds after 5.
   localparam bcd_t BCD_UNITS_MAX = 4'd9;
   localparam bcd_t BCD_TENS_MAX  = 4'd5;

   // MM:SS.cc as six BCD digits, most significant first.
   typedef struct packed {
      bcd_t min_t;
      bcd_t min_o;
      bcd_t sec_t;
      bcd_t sec_o;
      bcd_t cs_t;
      bcd_t cs_o;
   } bcd_time_t;

   localparam bcd_time_t BCD_TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Pushbutton front end: two-flop synchroniser followed by a rising-edge
// detector. A press of any length yields a single one-cycle pulse.
module btn_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_o
);

   logic meta_q;
   logic sync_q;
   logic sync_dly_q;

   // Synchronise the raw level, then keep one more copy for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         meta_q     <= btn_i;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
      end
   end

   assign press_o = sync_q & ~sync_dly_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: turns the 100 Hz wave into a single-cycle count enable,
// runs the start/stop/lap/clear FSM and keeps the MM:SS.cc BCD count plus
// the (possibly lap-frozen) display copy.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_LIMIT = 59
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clk_100hz,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic [3:0] min_t,
   output logic [3:0] min_o,
   output logic [3:0] sec_t,
   output logic [3:0] sec_o,
   output logic [3:0] cs_t,
   output logic [3:0] cs_o,
   output logic       running,
   output logic       lap_active,
   output logic       wrap,
   output logic [1:0] dbg_state_o
);

   localparam bcd_t LIM_T = bcd_t'(MIN_LIMIT / 10);
   localparam bcd_t LIM_O = bcd_t'(MIN_LIMIT % 10);

   logic      start_ev, lap_ev, clear_ev;
   logic      clk_100hz_q;
   logic      tick;
   logic      count_en;
   logic      at_max;
   state_e    state_q, state_d;
   bcd_time_t live_q, live_d, live_inc;
   bcd_time_t disp_q, disp_d;
   logic      wrap_q, wrap_d;

   btn_sync_edge u_start (.clk_i(clock), .rst_i(reset), .btn_i(btn_start), .press_o(start_ev));
   btn_sync_edge u_lap   (.clk_i(clock), .rst_i(reset), .btn_i(btn_lap),   .press_o(lap_ev));
   btn_sync_edge u_clear (.clk_i(clock), .rst_i(reset), .btn_i(btn_clear), .press_o(clear_ev));

   // The divider shares this clock, so a plain delay register is enough to
   // find the rising edge of the 100 Hz wave.
   assign tick     = clk_100hz & ~clk_100hz_q;
   assign count_en = tick & ((state_q == ST_RUN) | (state_q == ST_LAP));

   // Next state: clear beats start, start beats lap.
   always_comb begin
      state_d = state_q;
      if (clear_ev) begin
         state_d = ST_IDLE;
      end else if (start_ev) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_LAP:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end else if (lap_ev) begin
         case (state_q)
            ST_RUN:  state_d = ST_LAP;
            ST_LAP:  state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // BCD ripple increment of the live count, wrapping to zero after MIN_LIMIT:59.99.
   always_comb begin
      live_inc = live_q;
      at_max   = 1'b0;
      if (live_q.cs_o != BCD_UNITS_MAX) begin
         live_inc.cs_o = live_q.cs_o + 4'd1;
      end else begin
         live_inc.cs_o = 4'd0;
         if (live_q.cs_t != BCD_UNITS_MAX) begin
            live_inc.cs_t = live_q.cs_t + 4'd1;
         end else begin
            live_inc.cs_t = 4'd0;
            if (live_q.sec_o != BCD_UNITS_MAX) begin
               live_inc.sec_o = live_q.sec_o + 4'd1;
            end else begin
               live_inc.sec_o = 4'd0;
               if (live_q.sec_t != BCD_TENS_MAX) begin
                  live_inc.sec_t = live_q.sec_t + 4'd1;
               end else begin
                  live_inc.sec_t = 4'd0;
                  if ((live_q.min_t == LIM_T) && (live_q.min_o == LIM_O)) begin
                     live_inc.min_t = 4'd0;
                     live_inc.min_o = 4'd0;
                     at_max         = 1'b1;
                  end else if (live_q.min_o != BCD_UNITS_MAX) begin
                     live_inc.min_o = live_q.min_o + 4'd1;
                  end else begin
                     live_inc.min_o = 4'd0;
                     live_inc.min_t = live_q.min_t + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Live count, wrap pulse and display copy. A tick is judged against the
   // state held before the edge; the display holds only while staying in LAP,
   // so on LAP entry it captures the post-edge count including any tick.
   always_comb begin
      live_d = live_q;
      wrap_d = 1'b0;
      if (clear_ev) begin
         live_d = BCD_TIME_ZERO;
      end else if (count_en) begin
         live_d = live_inc;
         wrap_d = at_max;
      end
      if ((state_q == ST_LAP) && (state_d == ST_LAP)) begin
         disp_d = disp_q;
      end else begin
         disp_d = live_d;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_100hz_q <= 1'b0;
         state_q     <= ST_IDLE;
         live_q      <= BCD_TIME_ZERO;
         disp_q      <= BCD_TIME_ZERO;
         wrap_q      <= 1'b0;
      end else begin
         clk_100hz_q <= clk_100hz;
         state_q     <= state_d;
         live_q      <= live_d;
         disp_q      <= disp_d;
         wrap_q      <= wrap_d;
      end
   end

   assign min_t       = disp_q.min_t;
   assign min_o       = disp_q.min_o;
   assign sec_t       = disp_q.sec_t;
   assign sec_o       = disp_q.sec_o;
   assign cs_t        = disp_q.cs_t;
   assign cs_o        = disp_q.cs_o;
   assign running     = (state_q == ST_RUN) | (state_q == ST_LAP);
   assign lap_active  = (state_q == ST_LAP);
   assign wrap        = wrap_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl. The minute limit is set to 1 so the
// wrap boundary (01:59.99 -> 00:00.00) is reachable in a short run while
// still exercising the minute-units carry.
module tb_stopwatch_ctrl;

   localparam int MIN_LIMIT_TB = 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_LAP   = 2'd2;
   localparam logic [1:0] S_PAUSE = 2'd3;

   logic       clock;
   logic       reset;
   logic       clk_100hz;
   logic       btn_start, btn_lap, btn_clear;
   logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;
   logic       running, lap_active, wrap;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int live   = 0;
   logic [23:0] exp_q[$];

   stopwatch_ctrl #(.MIN_LIMIT(MIN_LIMIT_TB)) dut (
      .clock      (clock),
      .reset      (reset),
      .clk_100hz  (clk_100hz),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .btn_clear  (btn_clear),
      .min_t      (min_t),
      .min_o      (min_o),
      .sec_t      (sec_t),
      .sec_o      (sec_o),
      .cs_t       (cs_t),
      .cs_o       (cs_o),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap),
      .dbg_state_o(dbg_state)
   );

   // Clock and watchdog.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   // Reference conversion from a centisecond total to MM:SS.cc BCD digits.
   function automatic logic [23:0] to_bcd(input int t);
      int m, s, c;
      c = t % 100;
      s = (t / 100) % 60;
      m = t / 6000;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   // Advance the model by one tick, wrapping after MIN_LIMIT:59.99.
   function automatic int model_tick(input int t);
      return (t + 1) % ((MIN_LIMIT_TB + 1) * 6000);
   endfunction

   // Driver tasks; all start and end on a falling clock edge.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         clk_100hz = 1'b1;
         @(negedge clock);
         clk_100hz = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic press(input logic s, input logic l, input logic c);
      btn_start = s;
      btn_lap   = l;
      btn_clear = c;
      repeat (3) @(negedge clock);
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   // Button events and a 100 Hz rising edge land on the same clock edge.
   task automatic coincide(input logic s, input logic l);
      btn_start = s;
      btn_lap   = l;
      repeat (2) @(negedge clock);
      clk_100hz = 1'b1;
      @(negedge clock);
      clk_100hz = 1'b0;
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   // Scoreboard side.
   task automatic push_disp(input int t);
      exp_q.push_back(to_bcd(t));
   endtask

   task automatic check_disp(input string tag);
      logic [23:0] obs, exp;
      obs = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      clk_100hz = 1'b0;
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clear = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      push_disp(0); check_disp("reset_display");
      check_val("reset_running", {1'b0, running}, 2'd0);
      check_val("reset_lap", {1'b0, lap_active}, 2'd0);
      check_val("reset_wrap", {1'b0, wrap}, 2'd0);
      check_val("reset_state", dbg_state, S_IDLE);

      tick_n(5);
      push_disp(0); check_disp("idle_no_count");

      // Start and count 1.50 s.
      press(1'b1, 1'b0, 1'b0);
      check_val("start_state", dbg_state, S_RUN);
      tick_n(150); live = 150;
      push_disp(live); check_disp("run_150");
      check_val("run_running", {1'b0, running}, 2'd1);

      // Clear, then run 1.00 s and pause.
      press(1'b0, 1'b0, 1'b1); live = 0;
      push_disp(live); check_disp("clear_zero");
      check_val("clear_state", dbg_state, S_IDLE);
      press(1'b1, 1'b0, 1'b0);
      tick_n(100); live = 100;
      press(1'b1, 1'b0, 1'b0);
      tick_n(20);
      push_disp(live); check_disp("pause_hold");
      check_val("pause_state", dbg_state, S_PAUSE);
      check_val("pause_running", {1'b0, running}, 2'd0);

      // Resume to 2.00 s, lap freeze through 3 s, release.
      press(1'b1, 1'b0, 1'b0);
      check_val("resume_state", dbg_state, S_RUN);
      tick_n(100); live = 200;
      push_disp(live); check_disp("run_2s");
      press(1'b0, 1'b1, 1'b0);
      check_val("lap_state", dbg_state, S_LAP);
      check_val("lap_active", {1'b0, lap_active}, 2'd1);
      tick_n(300); live = 500;
      push_disp(200); check_disp("lap_frozen");
      check_val("lap_running", {1'b0, running}, 2'd1);
      press(1'b0, 1'b1, 1'b0);
      check_val("lap_release_state", dbg_state, S_RUN);
      push_disp(live); check_disp("lap_release");

      // LAP left by start goes to PAUSE showing the live count.
      press(1'b0, 1'b1, 1'b0);
      tick_n(10); live = 510;
      push_disp(500); check_disp("lap2_frozen");
      press(1'b1, 1'b0, 1'b0);
      check_val("lap_to_pause", dbg_state, S_PAUSE);
      push_disp(live); check_disp("lap_to_pause_disp");
      press(1'b0, 1'b1, 1'b0);
      check_val("pause_lap_ignored", dbg_state, S_PAUSE);

      // A long-held start gives a single event.
      btn_start = 1'b1;
      repeat (12) @(negedge clock);
      btn_start = 1'b0;
      repeat (3) @(negedge clock);
      check_val("held_start_once", dbg_state, S_RUN);

      // Lap entry coinciding with a tick: snapshot includes that tick.
      coincide(1'b0, 1'b1); live = model_tick(live);
      check_val("lap_tick_state", dbg_state, S_LAP);
      push_disp(live); check_disp("lap_entry_snapshot");
      tick_n(5);
      push_disp(live); check_disp("lap_entry_held");
      live = live + 5;
      coincide(1'b0, 1'b1); live = model_tick(live);
      check_val("lap_exit_tick_state", dbg_state, S_RUN);
      push_disp(live); check_disp("lap_exit_tick");

      // Start and lap together with a tick: start wins, tick per old state.
      coincide(1'b1, 1'b1); live = model_tick(live);
      check_val("coincide_run_state", dbg_state, S_PAUSE);
      push_disp(live); check_disp("coincide_run_count");
      coincide(1'b1, 1'b1);
      check_val("coincide_pause_state", dbg_state, S_RUN);
      push_disp(live); check_disp("coincide_pause_nocount");

      // Clear and start together while running: clear wins.
      press(1'b1, 1'b0, 1'b1); live = 0;
      check_val("clear_start_state", dbg_state, S_IDLE);
      push_disp(live); check_disp("clear_start_zero");

      // Run up to the wrap boundary.
      press(1'b1, 1'b0, 1'b0);
      tick_n((MIN_LIMIT_TB + 1) * 6000 - 1); live = (MIN_LIMIT_TB + 1) * 6000 - 1;
      push_disp(live); check_disp("at_max");
      check_val("no_wrap_before", {1'b0, wrap}, 2'd0);
      clk_100hz = 1'b1;
      @(negedge clock);
      clk_100hz = 1'b0;
      live = model_tick(live);
      push_disp(live); check_disp("wrap_zero");
      check_val("wrap_pulse", {1'b0, wrap}, 2'd1);
      check_val("wrap_running", {1'b0, running}, 2'd1);
      @(negedge clock);
      check_val("wrap_one_cycle", {1'b0, wrap}, 2'd0);

      // Asynchronous reset in the middle of a run.
      tick_n(3742); live = 3742;
      push_disp(live); check_disp("run_37_42");
      #2;
      reset = 1'b1;
      #1;
      push_disp(0); check_disp("async_reset_display");
      check_val("async_reset_running", {1'b0, running}, 2'd0);
      check_val("async_reset_state", dbg_state, S_IDLE);
      @(negedge clock);
      reset = 1'b0;
      tick_n(20);
      push_disp(0); check_disp("post_reset_no_count");
      check_val("post_reset_state", dbg_state, S_IDLE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
